// File: rtl/depacketizer_pkg.sv
// depacketizer_pkg: definitions shared by the depacketizer files.
//   - AXI4-Lite register offsets and their word indices (address bits [29:2])
//   - ERRORS register bit positions
//   - AXI response codes
//   - FSM state types
//   - write_register: byte-strobe merge helper, shared with the packetizer
package depacketizer_pkg;

  localparam logic [31:0] CONFIG_OFF = 32'h0000_0200;
  localparam logic [31:0] STATUS_OFF = 32'h0000_0204;
  localparam logic [31:0] PKTCNT_OFF = 32'h0000_0208;
  localparam logic [31:0] ERRORS_OFF = 32'h0000_020C;

  // Word indices compared against address bits [29:2].
  localparam logic [27:0] CONFIG_IDX = CONFIG_OFF[29:2];
  localparam logic [27:0] STATUS_IDX = STATUS_OFF[29:2];
  localparam logic [27:0] PKTCNT_IDX = PKTCNT_OFF[29:2];
  localparam logic [27:0] ERRORS_IDX = ERRORS_OFF[29:2];

  localparam int ERR_EARLY_LAST   = 0;
  localparam int ERR_MISSING_LAST = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
  typedef enum logic {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_t;

  // Merge new_val into old_val, one byte per strobe bit.
  function automatic logic [31:0] write_register(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/depacketizer_mm2s.sv
// depacketizer_mm2s: stream side of the depacketizer.
// Holds the 2-entry skid buffer, the beat counter, output tlast generation,
// the sticky framing-error flags and the good-packet counter.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   config_reg            index of the last beat of a packet; 0 = intake off
//   err_clr               W1C pulses for the error flags (bit positions from pkg)
//   s_tdata/tvalid/tready/tlast   input stream from the DMA
//   m_tdata/tvalid/tready/tlast   output sample stream (all registered)
//   counter               current beat index within the packet
//   pktcnt                good packets seen, saturating
//   err_flags             sticky {missing_last, early_last}
//
// Handshake: a beat moves when tvalid and tready are both high at a rising
// clock edge; a manager holds tdata/tlast stable while tvalid is high and
// tready is low, and never drops tvalid before the transfer.
module depacketizer_mm2s
  import depacketizer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           config_reg,
  input  logic [1:0]            err_clr,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [CNT_WIDTH-1:0]  counter,
  output logic [CNT_WIDTH-1:0]  pktcnt,
  output logic [1:0]            err_flags
);

  // Largest counter value; a CONFIG at or above it never ends a packet locally.
  localparam logic [32:0] CNT_LIMIT = 33'((64'd1 << CNT_WIDTH) - 64'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  // Entry 0 is the output register, entry 1 the skid slot.
  logic [DATA_WIDTH-1:0] data0, data1;
  logic                  last0, last1;
  logic                  v0, v1;

  logic push, pop, cfg_on, at_end;
  logic beat_last, good_evt;
  logic [1:0] err_evt;

  assign cfg_on   = (config_reg != 32'd0);
  assign s_tready = cfg_on & ~v1 & ~rst;
  assign push     = s_tvalid & s_tready;
  assign pop      = v0 & m_tready;

  assign at_end = ({1'b0, config_reg} < CNT_LIMIT) &&
                  ({1'b0, config_reg} == 33'(counter));

  always_comb begin
    err_evt                   = 2'b00;
    err_evt[ERR_EARLY_LAST]   = push & s_tlast & ~at_end;
    err_evt[ERR_MISSING_LAST] = push & ~s_tlast & at_end;
    good_evt                  = push & s_tlast & at_end;
    // Either boundary (DMA tlast or local count) closes the output packet.
    beat_last                 = s_tlast | at_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter   <= '0;
      pktcnt    <= '0;
      err_flags <= 2'b00;
    end else begin
      if (push) counter <= beat_last ? '0 : counter + CNT_ONE;
      if (good_evt && (pktcnt != '1)) pktcnt <= pktcnt + CNT_ONE;
      // A set event wins over a simultaneous clear.
      err_flags <= (err_flags & ~err_clr) | err_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data0 <= '0;
      data1 <= '0;
      last0 <= 1'b0;
      last1 <= 1'b0;
      v0    <= 1'b0;
      v1    <= 1'b0;
    end else begin
      case ({pop, push})
        2'b11: begin
          if (v1) begin
            data0 <= data1;
            last0 <= last1;
            data1 <= s_tdata;
            last1 <= beat_last;
          end else begin
            data0 <= s_tdata;
            last0 <= beat_last;
          end
        end
        2'b10: begin
          if (v1) begin
            data0 <= data1;
            last0 <= last1;
            v1    <= 1'b0;
          end else begin
            v0 <= 1'b0;
          end
        end
        2'b01: begin
          if (!v0) begin
            data0 <= s_tdata;
            last0 <= beat_last;
            v0    <= 1'b1;
          end else begin
            data1 <= s_tdata;
            last1 <= beat_last;
            v1    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_tdata  = data0;
  assign m_tlast  = last0;
  assign m_tvalid = v0;

endmodule

// File: rtl/depacketizer.sv
// depacketizer: accepts the DMA MM2S stream, checks packet length against
// CONFIG, regenerates packet boundaries and forwards samples downstream.
// AXI4-Lite register file:
//   0x200 CONFIG  RW   last-beat index (0 = disabled)
//   0x204 STATUS  RO   current beat counter
//   0x208 PKTCNT  RO   good packets, saturating
//   0x20C ERRORS  W1C  bit0 early_last, bit1 missing_last
//
// Ports:
//   aclk, areset                 clock, synchronous active-high reset
//   s_axis_mm2s_*                input stream from the DMA
//   m_axis_data_*                output sample stream
//   last                         copy of m_axis_data_tlast
//   s_axi_lite_*                 AXI4-Lite configuration subordinate
module depacketizer
  import depacketizer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_mm2s_tdata,
  input  logic                  s_axis_mm2s_tvalid,
  output logic                  s_axis_mm2s_tready,
  input  logic                  s_axis_mm2s_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready,
  output logic                  m_axis_data_tlast,
  output logic                  last,
  input  logic [31:0]           s_axi_lite_awaddr,
  input  logic [2:0]            s_axi_lite_awprot,
  input  logic                  s_axi_lite_awvalid,
  output logic                  s_axi_lite_awready,
  input  logic [31:0]           s_axi_lite_wdata,
  input  logic [3:0]            s_axi_lite_wstrb,
  input  logic                  s_axi_lite_wvalid,
  output logic                  s_axi_lite_wready,
  output logic [1:0]            s_axi_lite_bresp,
  output logic                  s_axi_lite_bvalid,
  input  logic                  s_axi_lite_bready,
  input  logic [31:0]           s_axi_lite_araddr,
  input  logic [2:0]            s_axi_lite_arprot,
  input  logic                  s_axi_lite_arvalid,
  output logic                  s_axi_lite_arready,
  output logic [31:0]           s_axi_lite_rdata,
  output logic [1:0]            s_axi_lite_rresp,
  output logic                  s_axi_lite_rvalid,
  input  logic                  s_axi_lite_rready
);

  logic [31:0]          config_reg;
  logic [1:0]           err_clr;
  logic [CNT_WIDTH-1:0] counter, pktcnt;
  logic [1:0]           err_flags;

  depacketizer_mm2s #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_mm2s (
    .clk       (aclk),
    .rst       (areset),
    .config_reg(config_reg),
    .err_clr   (err_clr),
    .s_tdata   (s_axis_mm2s_tdata),
    .s_tvalid  (s_axis_mm2s_tvalid),
    .s_tready  (s_axis_mm2s_tready),
    .s_tlast   (s_axis_mm2s_tlast),
    .m_tdata   (m_axis_data_tdata),
    .m_tvalid  (m_axis_data_tvalid),
    .m_tready  (m_axis_data_tready),
    .m_tlast   (m_axis_data_tlast),
    .counter   (counter),
    .pktcnt    (pktcnt),
    .err_flags (err_flags)
  );

  assign last = m_axis_data_tlast;

  // ---------------- write channel ----------------
  wr_state_t   wr_state, wr_state_next;
  logic        aw_have, w_have;
  logic [27:0] aw_idx;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        cfg_busy, aw_is_cfg, w_blocked, commit;

  // CONFIG may only change between packets, so a CONFIG write waits for counter==0.
  assign cfg_busy  = (counter != '0);
  assign aw_is_cfg = (s_axi_lite_awaddr[29:2] == CONFIG_IDX);
  assign w_blocked = cfg_busy & (aw_have ? (aw_idx == CONFIG_IDX)
                                         : (s_axi_lite_awvalid & aw_is_cfg));

  assign s_axi_lite_awready = ~areset & (wr_state == WR_IDLE) & ~aw_have &
                              ~(aw_is_cfg & cfg_busy);
  assign s_axi_lite_wready  = ~areset & (wr_state == WR_IDLE) & ~w_have & ~w_blocked;
  assign commit = (wr_state == WR_IDLE) & aw_have & w_have &
                  ~((aw_idx == CONFIG_IDX) & cfg_busy);
  assign s_axi_lite_bvalid  = (wr_state == WR_RESP);

  always_comb begin
    err_clr = 2'b00;
    if (commit && (aw_idx == ERRORS_IDX) && wstrb_q[0]) begin
      err_clr[ERR_EARLY_LAST]   = wdata_q[ERR_EARLY_LAST];
      err_clr[ERR_MISSING_LAST] = wdata_q[ERR_MISSING_LAST];
    end
  end

  always_comb begin
    wr_state_next = wr_state;
    case (wr_state)
      WR_IDLE: if (commit) wr_state_next = WR_RESP;
      WR_RESP: if (s_axi_lite_bready) wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) wr_state <= WR_IDLE;
    else        wr_state <= wr_state_next;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_have          <= 1'b0;
      w_have           <= 1'b0;
      aw_idx           <= '0;
      wdata_q          <= '0;
      wstrb_q          <= '0;
      config_reg       <= '0;
      s_axi_lite_bresp <= RESP_OKAY;
    end else begin
      if (s_axi_lite_awvalid && s_axi_lite_awready) begin
        aw_have <= 1'b1;
        aw_idx  <= s_axi_lite_awaddr[29:2];
      end
      if (s_axi_lite_wvalid && s_axi_lite_wready) begin
        w_have  <= 1'b1;
        wdata_q <= s_axi_lite_wdata;
        wstrb_q <= s_axi_lite_wstrb;
      end
      if (commit) begin
        aw_have <= 1'b0;
        w_have  <= 1'b0;
        if (aw_idx == CONFIG_IDX) config_reg <= write_register(config_reg, wdata_q, wstrb_q);
        s_axi_lite_bresp <= ((aw_idx == CONFIG_IDX) || (aw_idx == ERRORS_IDX)) ? RESP_OKAY
                                                                              : RESP_SLVERR;
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_t   rd_state, rd_state_next;
  logic [31:0] rd_mux;
  logic [1:0]  rd_resp;

  assign s_axi_lite_arready = ~areset & (rd_state == RD_IDLE);
  assign s_axi_lite_rvalid  = (rd_state == RD_DATA);

  always_comb begin
    rd_mux  = 32'd0;
    rd_resp = RESP_OKAY;
    case (s_axi_lite_araddr[29:2])
      CONFIG_IDX: rd_mux = config_reg;
      STATUS_IDX: rd_mux = 32'(counter);
      PKTCNT_IDX: rd_mux = 32'(pktcnt);
      ERRORS_IDX: rd_mux = {30'd0, err_flags};
      default:    rd_resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      RD_IDLE: if (s_axi_lite_arvalid) rd_state_next = RD_DATA;
      RD_DATA: if (s_axi_lite_rready) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) rd_state <= RD_IDLE;
    else        rd_state <= rd_state_next;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      s_axi_lite_rdata <= '0;
      s_axi_lite_rresp <= RESP_OKAY;
    end else if (s_axi_lite_arvalid && s_axi_lite_arready) begin
      s_axi_lite_rdata <= rd_mux;
      s_axi_lite_rresp <= rd_resp;
    end
  end

  // Protection bits and the byte/upper address bits are not decoded.
  logic unused_ok;
  assign unused_ok = ^{s_axi_lite_awprot, s_axi_lite_arprot,
                       s_axi_lite_awaddr[31:30], s_axi_lite_awaddr[1:0],
                       s_axi_lite_araddr[31:30], s_axi_lite_araddr[1:0]};

endmodule

// File: tb/tb_depacketizer.sv
// tb_depacketizer: self-checking bench for depacketizer.
module tb_depacketizer;

  localparam int DW = 32;
  localparam int CW = 32;

  localparam logic [31:0] A_CONFIG = 32'h200;
  localparam logic [31:0] A_STATUS = 32'h204;
  localparam logic [31:0] A_PKTCNT = 32'h208;
  localparam logic [31:0] A_ERRORS = 32'h20C;
  localparam logic [31:0] A_BAD    = 32'h300;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  int unsigned cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready = 1'b1, m_tlast, last;
  logic [31:0]   awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [2:0]    awprot = '0, arprot = '0;
  logic [3:0]    wstrb = '0;
  logic          awvalid = 1'b0, awready, wvalid = 1'b0, wready;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready = 1'b0, arvalid = 1'b0, arready, rvalid, rready = 1'b0;

  depacketizer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_mm2s_tdata(s_tdata), .s_axis_mm2s_tvalid(s_tvalid),
    .s_axis_mm2s_tready(s_tready), .s_axis_mm2s_tlast(s_tlast),
    .m_axis_data_tdata(m_tdata), .m_axis_data_tvalid(m_tvalid),
    .m_axis_data_tready(m_tready), .m_axis_data_tlast(m_tlast),
    .last(last),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awprot(awprot),
    .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb),
    .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
    .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
    .s_axi_lite_araddr(araddr), .s_axi_lite_arprot(arprot),
    .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
    .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
    .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got no event within bound, expected event", name);
  endtask

  // ---------------- scoreboard ----------------
  logic [DW:0]  exp_q[$];      // {tlast, tdata}
  int unsigned  exp_cyc_q[$];  // cycle at which the input was accepted
  bit           lat_check = 1'b0;

  logic          prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_rst = 1'b1;
  logic [DW-1:0] prev_d = '0;
  logic [DW:0]   sb_e;
  int unsigned   sb_c;

  always @(negedge aclk) begin : monitor
    if (!prev_rst && !areset && prev_v && !prev_r)
      check("hold_stable", {30'd0, m_tvalid, m_tlast, m_tdata}, {30'd0, 1'b1, prev_l, prev_d});
    if (!areset && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got 0x%0h, expected nothing", m_tdata);
      end else begin
        sb_e = exp_q.pop_front();
        sb_c = exp_cyc_q.pop_front();
        check("beat", {31'd0, m_tlast, m_tdata}, {31'd0, sb_e});
        check("last_pin", {63'd0, last}, {63'd0, sb_e[DW]});
        if (lat_check) check("latency", 64'(cyc - sb_c), 64'd1);
      end
    end
    prev_v   = m_tvalid;
    prev_r   = m_tready;
    prev_l   = m_tlast;
    prev_d   = m_tdata;
    prev_rst = areset;
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic el);
    int n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_tready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (!s_tready) fail_now("s_tready_timeout");
    else begin
      exp_q.push_back({el, d});
      exp_cyc_q.push_back(cyc);
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n = 0;
    bit aw_done = 0, w_done = 0, a_rdy, w_rdy;
    @(posedge aclk); #1;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 200) begin
      @(negedge aclk);
      a_rdy = awready;
      w_rdy = wready;
      @(posedge aclk); #1;
      if (awvalid && a_rdy) begin awvalid = 1'b0; aw_done = 1; end
      if (wvalid && w_rdy) begin wvalid = 1'b0; w_done = 1; end
      n++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    resp    = 2'bxx;
    if (!(aw_done && w_done)) begin
      fail_now("aw_w_timeout");
    end else begin
      bready = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!bvalid && n < 50) begin
        @(negedge aclk);
        n++;
      end
      if (!bvalid) fail_now("bvalid_timeout");
      else resp = bresp;
      @(posedge aclk); #1;
      bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    d = 'x;
    resp = 2'bxx;
    @(posedge aclk); #1;
    araddr = a;
    arvalid = 1'b1;
    @(negedge aclk);
    while (!arready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!rvalid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    if (!rvalid) fail_now("rvalid_timeout");
    else begin
      d = rdata;
      resp = rresp;
    end
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic reg_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, d, r);
    check(name, {30'd0, r, d}, {30'd0, 2'b00, exp});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge aclk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain");
    @(posedge aclk); #1;
  endtask

  task automatic reset_dut();
    @(posedge aclk); #1;
    areset   = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int            sc;
    logic [DW-1:0] data;
    logic          in_last;
    logic          exp_last;
  } vec_t;

  vec_t vecs[14];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [1:0]  resp;
    logic [31:0] rd;
    bit          done;
    int          cfg, exp_pk, exp_err;

    // Scenario 1: clean packet. Scenario 2: early tlast. Scenario 3: missing tlast.
    vecs[0]  = '{1, 32'hA0, 1'b0, 1'b0};
    vecs[1]  = '{1, 32'hA1, 1'b0, 1'b0};
    vecs[2]  = '{1, 32'hA2, 1'b0, 1'b0};
    vecs[3]  = '{1, 32'hA3, 1'b1, 1'b1};
    vecs[4]  = '{2, 32'hB0, 1'b0, 1'b0};
    vecs[5]  = '{2, 32'hB1, 1'b1, 1'b1};
    vecs[6]  = '{2, 32'hB2, 1'b0, 1'b0};
    vecs[7]  = '{2, 32'hB3, 1'b0, 1'b0};
    vecs[8]  = '{2, 32'hB4, 1'b0, 1'b0};
    vecs[9]  = '{2, 32'hB5, 1'b1, 1'b1};
    vecs[10] = '{3, 32'hC0, 1'b0, 1'b0};
    vecs[11] = '{3, 32'hC1, 1'b0, 1'b1};
    vecs[12] = '{3, 32'hC2, 1'b0, 1'b0};
    vecs[13] = '{3, 32'hC3, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset_ctrl",
          {52'd0, m_tvalid, m_tlast, last, s_tready, awready, wready, arready,
           bvalid, rvalid, bresp, rresp},
          64'd0);
    check("reset_data", {m_tdata, rdata}, 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    reg_check("cfg_after_reset", A_CONFIG, 32'd0);

    // Table-driven scenarios 1..3
    for (int sc = 1; sc <= 3; sc++) begin
      reset_dut();
      cfg     = (sc == 3) ? 1 : 3;
      exp_pk  = 1;
      exp_err = (sc == 1) ? 0 : ((sc == 2) ? 1 : 2);
      axi_write(A_CONFIG, 32'(cfg), 4'hF, resp);
      check("cfg_write_resp", {62'd0, resp}, 64'd0);
      lat_check = (sc == 1);
      for (int i = 0; i < 14; i++)
        if (vecs[i].sc == sc) send_beat(vecs[i].data, vecs[i].in_last, vecs[i].exp_last);
      wait_drain();
      lat_check = 1'b0;
      reg_check("pktcnt", A_PKTCNT, 32'(exp_pk));
      reg_check("errors", A_ERRORS, 32'(exp_err));
      reg_check("status_idle", A_STATUS, 32'd0);
      if (sc == 2) begin
        axi_write(A_ERRORS, 32'h1, 4'hF, resp);
        check("w1c_resp", {62'd0, resp}, 64'd0);
        reg_check("errors_cleared", A_ERRORS, 32'd0);
      end
    end

    // Scenario 4: random output backpressure, continuous input
    reset_dut();
    axi_write(A_CONFIG, 32'd7, 4'hF, resp);
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++)
          send_beat($urandom, (i % 8) == 7, (i % 8) == 7);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge aclk); #1;
          m_tready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    m_tready = 1'b1;
    wait_drain();
    reg_check("rand_pktcnt", A_PKTCNT, 32'd2);
    reg_check("rand_errors", A_ERRORS, 32'd0);

    // Scenario 5: disabled intake, stalled CONFIG write, bad accesses
    reset_dut();
    s_tdata  = 32'h55;
    s_tvalid = 1'b1;
    repeat (4) @(negedge aclk);
    check("disabled_tready", {63'd0, s_tready}, 64'd0);
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    axi_write(A_CONFIG, 32'd3, 4'hF, resp);
    send_beat(32'hD0, 1'b0, 1'b0);
    send_beat(32'hD1, 1'b0, 1'b0);
    reg_check("status_mid", A_STATUS, 32'd2);
    fork
      axi_write(A_CONFIG, 32'd5, 4'hF, resp);
      begin
        repeat (3) @(negedge aclk);
        check("aw_stall", {62'd0, awvalid, awready}, {62'd0, 1'b1, 1'b0});
        check("w_stall", {63'd0, wready}, 64'd0);
        @(posedge aclk); #1;
        send_beat(32'hD2, 1'b0, 1'b0);
        send_beat(32'hD3, 1'b1, 1'b1);
      end
    join
    check("stalled_write_resp", {62'd0, resp}, 64'd0);
    wait_drain();
    reg_check("cfg_new", A_CONFIG, 32'd5);
    reg_check("pktcnt_mid", A_PKTCNT, 32'd1);
    axi_write(A_CONFIG, 32'h0000_AB00, 4'h2, resp);
    reg_check("cfg_strobe", A_CONFIG, 32'h0000_AB05);
    axi_write(A_STATUS, 32'd9, 4'hF, resp);
    check("ro_write_resp", {62'd0, resp}, 64'd2);
    axi_read(A_BAD, rd, resp);
    check("bad_read", {30'd0, resp, rd}, {30'd0, 2'b10, 32'd0});

    // Scenario 6: reset with a beat buffered and a flag set
    reset_dut();
    axi_write(A_CONFIG, 32'd3, 4'hF, resp);
    m_tready = 1'b0;
    send_beat(32'h66, 1'b1, 1'b1);
    @(negedge aclk);
    check("buffered", {63'd0, m_tvalid}, 64'd1);
    reg_check("errors_before_rst", A_ERRORS, 32'd1);
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge aclk);
    check("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    reg_check("rst_status", A_STATUS, 32'd0);
    reg_check("rst_config", A_CONFIG, 32'd0);
    reg_check("rst_errors", A_ERRORS, 32'd0);
    m_tready = 1'b1;
    repeat (3) @(posedge aclk);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
